// File: rtl/wide_result_serializer.sv
// Captures one NUM_OF_CORES*512-bit result block and writes it to BRAM as 32-bit words with ready backpressure.
// Define SERIALIZER_MSW_FIRST_EN to send the most-significant word to the lowest address (LSW first otherwise).
//
// state  | meaning
// S_IDLE | waiting for wide_din_valid; capture on the edge it is sampled
// S_SEND | bram_we held with addr/data until bram_ready accepts each word
// S_DONE | single-cycle done pulse; busy still high
module wide_result_serializer #(
   parameter int NUM_OF_CORES    = 1,
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int BASE_ADDR       = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_OF_CORES*512-1:0] wide_din,
   input  logic                        wide_din_valid,
   output logic                        wide_din_read,
   output logic [BRAM_ADDR_WIDTH-1:0]  bram_addr,
   output logic [31:0]                 bram_dout,
   output logic                        bram_we,
   input  logic                        bram_ready,
   output logic                        busy,
   output logic                        done
);
   localparam int WIDE  = NUM_OF_CORES*512;
   localparam int WORDS = WIDE/32;
   localparam int CW    = $clog2(WORDS);
   localparam logic [BRAM_ADDR_WIDTH-1:0] BASE     = BRAM_ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CW-1:0]              LAST_CNT = CW'(WORDS-1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

   state_t                     state_q;
   logic [WIDE-1:0]            shift_q;
   logic [CW-1:0]              remain_q;
   logic                       read_q;
   logic                       we_q;
   logic                       busy_q;
   logic                       done_q;
   logic [BRAM_ADDR_WIDTH-1:0] addr_q;
   logic [31:0]                dout_q;

   logic [31:0]     first_word_d;
   logic [WIDE-1:0] first_rest_d;
   logic [31:0]     next_word_d;
   logic [WIDE-1:0] next_rest_d;

   // Word 0 goes straight to the output register; the shifter holds the words still to send.
`ifdef SERIALIZER_MSW_FIRST_EN
   assign first_word_d = wide_din[WIDE-1 -: 32];
   assign first_rest_d = wide_din << 32;
   assign next_word_d  = shift_q[WIDE-1 -: 32];
   assign next_rest_d  = shift_q << 32;
`else
   assign first_word_d = wide_din[31:0];
   assign first_rest_d = wide_din >> 32;
   assign next_word_d  = shift_q[31:0];
   assign next_rest_d  = shift_q >> 32;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         remain_q <= '0;
         read_q   <= 1'b0;
         we_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         addr_q   <= '0;
         dout_q   <= '0;
      end else begin
         read_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (wide_din_valid) begin
                  state_q  <= S_SEND;
                  shift_q  <= first_rest_d;
                  dout_q   <= first_word_d;
                  addr_q   <= BASE;
                  remain_q <= LAST_CNT;
                  read_q   <= 1'b1;
                  we_q     <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            S_SEND: begin
               if (bram_ready) begin
                  if (remain_q == '0) begin
                     we_q    <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     remain_q <= remain_q - 1'b1;
                     addr_q   <= addr_q + 1'b1;
                     dout_q   <= next_word_d;
                     shift_q  <= next_rest_d;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wide_din_read = read_q;
   assign bram_addr     = addr_q;
   assign bram_dout     = dout_q;
   assign bram_we       = we_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_wide_result_serializer.sv
// Directed bench: A (BASE 0x20, 10-bit addr) and B (BASE 0xC, 4-bit addr) share stimulus; C has two lanes.
module tb_wide_result_serializer;
   logic          clk = 1'b0;
   logic          rst;
   logic [511:0]  din_ab;
   logic          valid_ab;
   logic          ready_ab;
   logic [1023:0] din_c;
   logic          valid_c;
   logic          ready_c;

   logic        a_read, a_we, a_busy, a_done;
   logic [9:0]  a_addr;
   logic [31:0] a_dout;
   logic        b_read, b_we, b_busy, b_done;
   logic [3:0]  b_addr;
   logic [31:0] b_dout;
   logic        c_read, c_we, c_busy, c_done;
   logic [9:0]  c_addr;
   logic [31:0] c_dout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wide_result_serializer #(.NUM_OF_CORES(1), .BRAM_ADDR_WIDTH(10), .BASE_ADDR(32'h20)) u_a (
      .clk(clk), .reset(rst), .wide_din(din_ab), .wide_din_valid(valid_ab), .wide_din_read(a_read),
      .bram_addr(a_addr), .bram_dout(a_dout), .bram_we(a_we), .bram_ready(ready_ab),
      .busy(a_busy), .done(a_done));

   wide_result_serializer #(.NUM_OF_CORES(1), .BRAM_ADDR_WIDTH(4), .BASE_ADDR(32'hC)) u_b (
      .clk(clk), .reset(rst), .wide_din(din_ab), .wide_din_valid(valid_ab), .wide_din_read(b_read),
      .bram_addr(b_addr), .bram_dout(b_dout), .bram_we(b_we), .bram_ready(ready_ab),
      .busy(b_busy), .done(b_done));

   wide_result_serializer #(.NUM_OF_CORES(2), .BRAM_ADDR_WIDTH(10), .BASE_ADDR(0)) u_c (
      .clk(clk), .reset(rst), .wide_din(din_c), .wide_din_valid(valid_c), .wide_din_read(c_read),
      .bram_addr(c_addr), .bram_dout(c_dout), .bram_we(c_we), .bram_ready(ready_c),
      .busy(c_busy), .done(c_done));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Block content: word at bit position 32*idx.
   function automatic logic [31:0] blk_word(input int typ, input int idx);
      case (typ)
         0:       return 32'(idx);
         1:       return 32'hA5A5A5A5;
         default: return 32'h9E370000 ^ (32'(idx) * 32'h01001001);
      endcase
   endfunction

   function automatic logic [1023:0] make_blk(input int typ, input int words);
      logic [1023:0] b;
      b = '0;
      for (int i = 0; i < words; i++) b[32*i +: 32] = blk_word(typ, i);
      return b;
   endfunction

   // Expected data of the k-th write.
   function automatic logic [31:0] exp_data(input int typ, input int k, input int words);
`ifdef SERIALIZER_MSW_FIRST_EN
      return blk_word(typ, words - 1 - k);
`else
      return blk_word(typ, k);
`endif
   endfunction

   // Entered at a negedge while A/B are idle; returns at the negedge of the next IDLE cycle.
   task automatic xfer_ab(input int typ, input bit bp, input bit inject, input int abort_at);
      int k;
      int cyc;
      int stall_n;
      bit tog;
      bit rdy;
      din_ab   = make_blk(typ, 16)[511:0];
      valid_ab = 1'b1;
      ready_ab = 1'b1;
      @(negedge clk);
      valid_ab = 1'b0;
      chk("read_pulse_a", 64'(a_read), 64'd1);
      chk("read_pulse_b", 64'(b_read), 64'd1);
      k = 0; cyc = 1; stall_n = 0; tog = 1'b1;
      while (k < 16 && cyc < 200) begin
         if (cyc > 1) begin
            chk("read_once_a", 64'(a_read), 64'd0);
            chk("read_once_b", 64'(b_read), 64'd0);
         end
         chk("we_a", 64'(a_we), 64'd1);
         chk("we_b", 64'(b_we), 64'd1);
         chk("busy_a", 64'(a_busy), 64'd1);
         chk("done_early_a", 64'(a_done), 64'd0);
         chk("addr_a", 64'(a_addr), 64'(10'(32'h20 + k)));
         chk("addr_b", 64'(b_addr), 64'(4'(32'hC + k)));
         chk("data_a", 64'(a_dout), 64'(exp_data(typ, k, 16)));
         chk("data_b", 64'(b_dout), 64'(exp_data(typ, k, 16)));
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         rdy = 1'b1;
         if (bp) begin
            if (k == 3 && stall_n < 5) begin
               rdy = 1'b0;
               stall_n++;
            end else if (stall_n == 5) begin
               rdy = tog;
               tog = ~tog;
            end
         end
         if (inject && k == 8) begin
            valid_ab = 1'b1;
            din_ab   = make_blk(1, 16)[511:0];
         end
         ready_ab = rdy;
         if (rdy) k++;
         @(negedge clk);
         cyc++;
      end
      chk("xfer_timeout", 64'(cyc < 200), 64'd1);
      chk("done_a", 64'(a_done), 64'd1);
      chk("done_b", 64'(b_done), 64'd1);
      chk("we_off_a", 64'(a_we), 64'd0);
      chk("busy_done_a", 64'(a_busy), 64'd1);
      chk("read_done_a", 64'(a_read), 64'd0);
      if (!bp) chk("done_latency", 64'(cyc), 64'd17);
      ready_ab = 1'b1;
      @(negedge clk);
      chk("done_once_a", 64'(a_done), 64'd0);
      chk("idle_busy_a", 64'(a_busy), 64'd0);
      chk("idle_busy_b", 64'(b_busy), 64'd0);
      chk("idle_read_a", 64'(a_read), 64'd0);
      chk("idle_we_a", 64'(a_we), 64'd0);
   endtask

   initial begin
      int cyc;
      rst      = 1'b1;
      din_ab   = '0;
      valid_ab = 1'b0;
      ready_ab = 1'b1;
      din_c    = '0;
      valid_c  = 1'b0;
      ready_c  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      chk("rst_read", 64'(a_read), 64'd0);
      chk("rst_addr", 64'(a_addr), 64'd0);
      chk("rst_dout", 64'(a_dout), 64'd0);
      chk("rst_we", 64'(a_we), 64'd0);
      chk("rst_busy", 64'(a_busy), 64'd0);
      chk("rst_done", 64'(a_done), 64'd0);
      chk("rst_c_we", 64'(c_we), 64'd0);

      // Basic transfer, then backpressure.
      xfer_ab(0, 1'b0, 1'b0, -1);
      xfer_ab(2, 1'b1, 1'b0, -1);

      // Second block offered mid-transfer must wait for IDLE, then arrive intact.
      xfer_ab(0, 1'b0, 1'b1, -1);
      chk("held_valid", 64'(valid_ab), 64'd1);
      xfer_ab(1, 1'b0, 1'b0, -1);

      // Reset at word 7 drops the transfer without a done pulse.
      xfer_ab(2, 1'b0, 1'b0, 7);
      chk("abort_we", 64'(a_we), 64'd0);
      chk("abort_busy", 64'(a_busy), 64'd0);
      chk("abort_addr", 64'(a_addr), 64'd0);
      chk("abort_b_we", 64'(b_we), 64'd0);
      repeat (3) begin
         chk("abort_no_done_a", 64'(a_done), 64'd0);
         chk("abort_no_done_b", 64'(b_done), 64'd0);
         @(negedge clk);
      end
      xfer_ab(0, 1'b0, 1'b0, -1);

      // Two-lane instance: 32 words at ascending addresses from 0.
      din_c   = make_blk(0, 32);
      valid_c = 1'b1;
      @(negedge clk);
      valid_c = 1'b0;
      chk("c_read", 64'(c_read), 64'd1);
      for (int k = 0; k < 32; k++) begin
         chk("c_we", 64'(c_we), 64'd1);
         chk("c_addr", 64'(c_addr), 64'(k));
         chk("c_data", 64'(c_dout), 64'(exp_data(0, k, 32)));
         @(negedge clk);
      end
      chk("c_done", 64'(c_done), 64'd1);
      chk("c_we_off", 64'(c_we), 64'd0);
      @(negedge clk);
      chk("c_idle", 64'(c_busy), 64'd0);

      // Valid with bram_ready low while idle: ready is irrelevant to capture.
      ready_ab = 1'b0;
      din_ab   = make_blk(0, 16)[511:0];
      valid_ab = 1'b1;
      @(negedge clk);
      valid_ab = 1'b0;
      chk("stall0_read", 64'(a_read), 64'd1);
      cyc = 0;
      repeat (4) begin
         @(negedge clk);
         chk("stall0_addr", 64'(a_addr), 64'h20);
         chk("stall0_data", 64'(a_dout), 64'(exp_data(0, 0, 16)));
      end
      ready_ab = 1'b1;
      while (a_done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      chk("stall0_done_cycles", 64'(cyc), 64'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wide_result_serializer.md
Name: wide_result_serializer

Overview:
- Return path from the Montgomery wrapper to the processor-visible BRAM.
- Captures one wide result block (NUM_OF_CORES*512 bits) from the wrapper's dout/valid/read handshake.
- Emits the block as consecutive 32-bit words on a BRAM write port with ready backpressure.
- Pulses done when the last word is accepted; the counterpart of the word-to-wide packer on the input side.

Parameters:
- NUM_OF_CORES, 1, number of 512-bit lanes; WIDE = NUM_OF_CORES*512, WORDS = WIDE/32.
- BRAM_ADDR_WIDTH, 10, width of the output word address.
- BASE_ADDR, 0, word address of word 0; must be < 2**BRAM_ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wide_din  in  WIDE  result block from Montgomery wrapper.
- wide_din_valid  in  1  wide_din holds a new block.
- wide_din_read  out  1  one-cycle pulse: block captured, wrapper may drop valid.
- bram_addr  out  BRAM_ADDR_WIDTH  word address of current write.
- bram_dout  out  32  word being written.
- bram_we  out  1  write request; held with addr/data until accepted.
- bram_ready  in  1  sink accepts the write in any cycle where bram_we and bram_ready are both 1.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset state: every output reset to 0 (wide_din_read, bram_addr, bram_dout, bram_we, busy, done); state IDLE; index 0; shift register cleared.
- Clock and reset: one clock; reset is synchronous and active-high.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - If wide_din_valid is sampled 1 at edge t, register wide_din.
  - In cycle t+1: wide_din_read=1 (exactly one cycle), busy=1, bram_we=1, bram_addr=BASE_ADDR, bram_dout=word 0.
  - Go to SEND.
- Word order: word k = wide_din[32k+31:32k]; least-significant word first by default.
- SEND, stall: when bram_we=1 and bram_ready=0, hold addr and data unchanged; a stall has no length limit.
- SEND, accept, k<WORDS-1: advance to word k+1 next cycle; bram_addr increments by 1, with no bubble.
- SEND, accept, k=WORDS-1: next cycle bram_we=0, done=1, state DONE.
- DONE:
  - Lasts exactly one cycle; then busy=0, state IDLE.
  - A new capture is possible in the IDLE cycle that follows.
- Address arithmetic: bram_addr = (BASE_ADDR + k) mod 2**BRAM_ADDR_WIDTH; wraps silently past the top.
- Throughput: with bram_ready tied 1, valid sampled at edge t gives:
  - word 0 in cycle t+1;
  - last word in cycle t+WORDS;
  - done in cycle t+WORDS+1.
- Re-arm and busy rules:
  - The earliest next capture edge is t+WORDS+2.
  - wide_din_valid while busy is ignored; wide_din_read is not asserted, and the block waits for IDLE.
  - Valid held high continuously with the same data is captured only once per IDLE entry. The wrapper must deassert valid after the read pulse.
- Reset mid-operation: return to the reset state at the next edge. Remaining words are discarded, and no done pulse is issued.
- bram_ready is ignored when bram_we=0.

Optional Feature:
- Macro: SERIALIZER_MSW_FIRST_EN.
- Defined: word order reversed. Word k emitted at bram_addr BASE_ADDR+k is wide_din[WIDE-1-32k : WIDE-32-32k], so the most-significant word goes to the lowest address.
- Not defined: least-significant word first, as above.
- All timing is identical in both modes.

Test Plan:
- Basic transfer: reset 3 cycles; NUM_OF_CORES=1, BASE_ADDR=0x20, bram_ready=1. Present wide_din = {16 words 0x0000000F..0x00000000} with valid for 1 cycle. Expect:
  - wide_din_read pulses once;
  - 16 writes, addr 0x20..0x2F, data 0x00000000..0x0000000F;
  - done in the cycle after the last write;
  - total 18 cycles from the valid edge to return to IDLE.
- Backpressure: same block, bram_ready=0 for 5 cycles at word 3, then toggling 1/0. Expect addr 0x23 / data 0x00000003 held stable across the stall, no word lost or duplicated, done only after word 15 is accepted.
- Busy rejection: assert wide_din_valid with a second block (all 0xA5A5A5A5) during SEND. Expect no wide_din_read until the cycle after done. The second block is then serialized intact.
- Address wrap: BRAM_ADDR_WIDTH=4, BASE_ADDR=0xC. Expect addresses 0xC,0xD,0xE,0xF,0x0..0xB.
- Mid-transfer reset: assert reset at word 7. Expect next cycle bram_we=0, busy=0, done never pulses. The next block starts at BASE_ADDR with word 0.
- Optional feature: with SERIALIZER_MSW_FIRST_EN and NUM_OF_CORES=2, present block word k = k. Expect 32 writes with data 31 down to 0 at ascending addresses.
